ram_fifo_ctrl: RTL and testbench
================================

# ram_fifo_ctrl

Parametrised synchronous memory block with two run-time modes: addressed single-port RAM, and circular FIFO with full/empty/count status and sticky overflow/underflow flags. Successor to the fixed 4x4 board RAM. Sits behind the board switch/LED glue in `top`, with switches driving requests and LEDs/LCD showing data and status. Width and depth are parameters; memory contents are never cleared by reset.

## Interface
- `ADDR_WIDTH`, default 2: address bits; depth = 2**ADDR_WIDTH.
- `DATA_WIDTH`, default 4: word width.
- `clk_2`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mode`  in  1  0 = RAM, 1 = FIFO.
- `wr_en`  in  1  write/push request.
- `rd_en`  in  1  read/pop request.
- `addr`  in  ADDR_WIDTH  RAM-mode address; ignored in FIFO mode.
- `wdata`  in  DATA_WIDTH  write/push data.
- `rdata`  out  DATA_WIDTH  registered read data; holds the last value read.
- `rvalid`  out  1  one-cycle pulse: `rdata` updated this cycle.
- `count`  out  ADDR_WIDTH+1  FIFO occupancy, 0..depth.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == depth`.
- `ovf`  out  1  sticky: push rejected because full.
- `udf`  out  1  sticky: pop rejected because empty.

## Operation
- Internal strobes `wr_s`/`rd_s` are derived from `wr_en`/`rd_en` (see Configuration).
- RAM mode:
  - `wr_s`: `mem[addr] <= wdata`.
  - `rd_s` with no `wr_s`: `rdata <= mem[addr]` and `rvalid` pulses.
  - Both strobes: the write wins and no read occurs.
  - `count`, `ovf` and `udf` hold.
- FIFO mode, state `wr_ptr`, `rd_ptr` (ADDR_WIDTH bits) and `count`:
  - Push when `wr_s && !full`: `mem[wr_ptr] <= wdata`, `wr_ptr++`.
  - Pop when `rd_s && !empty`: `rdata <= mem[rd_ptr]`, `rd_ptr++`, `rvalid` pulses.
  - Pointers wrap modulo depth.
  - `count` +1 on push only, -1 on pop only, unchanged on both.
  - Push while full is rejected and sets `ovf`, even if a pop is accepted in the same cycle. The pop still proceeds, so `count` becomes depth-1.
  - Pop while empty is rejected and sets `udf`. A simultaneous push still proceeds, so `count` becomes 1.
  - A rejected op changes no data, no pointers and no `rdata`.
- Mode change: when `mode` differs from its registered copy `mode_q`, that cycle:
  - Clears both pointers, `count`, `ovf` and `udf`.
  - Ignores both strobes.
  - Leaves memory untouched.
- Reset (any cycle, including mid-operation) forces:
  - `rdata=0`, `rvalid=0`, `count=0`, `empty=1`, `full=0`, `ovf=0`, `udf=0`.
  - Pointers to 0; `mode_q <= mode`; edge registers to 0.
  - Strobes are ignored in the reset cycle.

## Timing
- Request sampled at edge N:
  - Memory write visible to a read sampled at edge N+1.
  - `rdata`/`rvalid` valid after edge N (latency 1).
- `count`, `ovf` and `udf` are registered and update at the same edge as the op. `empty`/`full` are decoded combinationally from registered `count`.
- Back-to-back ops every cycle are supported. Push then pop of the same word on consecutive cycles returns the new data.

## Configuration
- `RAM_FIFO_EDGE_EN` defined:
  - `wr_s = wr_en & ~wr_q` and `rd_s = rd_en & ~rd_q`, with `wr_q`/`rd_q` registered copies. A level held high yields exactly one op in its first sampled cycle, which suits slow switch inputs.
  - An input held high through reset yields one op in the first cycle after reset.
- Not defined: `wr_s = wr_en`, `rd_s = rd_en`, giving one op per cycle while high. Edge registers are not instantiated.

## Test plan
- RAM write/read: after reset, write 4'hA to addr 2, then read addr 2 -> `rdata=4'hA`, `rvalid` pulses one cycle. Read addr 1 -> `rdata=0` only if previously written 0; otherwise its last written value.
- FIFO fill/overflow: push 1,2,3,4 -> `count=4`, `full=1`. Push 5 -> rejected, `ovf=1`, `count=4`. Pop four times -> 1,2,3,4, then `empty=1`.
- FIFO underflow/simultaneous: on empty, pop -> `udf=1`, `rdata` unchanged. Push 7 and pop together on empty -> `count=1`, no `rvalid`. Push 8 and pop together -> `rdata=7`, `count=1`.
- Wrap-around: push 3, pop 3, push 4 words 9..C -> `count=4`, pops return 9,A,B,C, and `wr_ptr` has wrapped through 0.
- Mode change and reset: FIFO with `count=2` and `ovf=1`; toggle `mode` -> `count=0`, `ovf=0`. Assert `reset` during a push -> push ignored, all outputs take their reset values.
- `RAM_FIFO_EDGE_EN`: hold `wr_en` high 5 cycles in FIFO mode -> `count=1`. Without the macro -> `count=4`, `ovf=1`.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// Dual-mode memory: addressed single-port RAM (mode=0) or circular FIFO (mode=1).
// Optional macro RAM_FIFO_EDGE_EN turns wr_en/rd_en into rising-edge strobes.
module ram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic                  mode,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  ovf,
  output logic                  udf
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  mode_q;
  logic                  wr_s, rd_s;

`ifdef RAM_FIFO_EDGE_EN
  // Edge registers keep running in every non-reset cycle, including mode changes.
  logic wr_q, rd_q;
  always_ff @(posedge clk_2) begin
    if (reset) begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      wr_q <= wr_en;
      rd_q <= rd_en;
    end
  end
  assign wr_s = wr_en & ~wr_q;
  assign rd_s = rd_en & ~rd_q;
`else
  assign wr_s = wr_en;
  assign rd_s = rd_en;
`endif

  logic mode_chg, active;
  logic ram_wr, ram_rd, push_ok, pop_ok, push_rej, pop_rej;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign mode_chg = (mode != mode_q);
  assign active   = !reset && !mode_chg;

  assign ram_wr   = active && !mode && wr_s;
  assign ram_rd   = active && !mode && rd_s && !wr_s;
  assign push_ok  = active && mode && wr_s && !full;
  assign pop_ok   = active && mode && rd_s && !empty;
  assign push_rej = active && mode && wr_s && full;
  assign pop_rej  = active && mode && rd_s && empty;

  // Storage has no reset; contents survive reset and mode changes.
  always_ff @(posedge clk_2) begin
    if (ram_wr)
      mem[addr] <= wdata;
    else if (push_ok)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
      mode_q <= mode;
    end else if (mode_chg) begin
      rvalid <= 1'b0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
      mode_q <= mode;
    end else begin
      rvalid <= ram_rd || pop_ok;
      if (ram_rd)
        rdata <= mem[addr];
      else if (pop_ok)
        rdata <= mem[rd_ptr];
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (push_ok && !pop_ok)
        count <= count + CNT_ONE;
      else if (pop_ok && !push_ok)
        count <= count - CNT_ONE;
      if (push_rej)
        ovf <= 1'b1;
      if (pop_rej)
        udf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl (ADDR_WIDTH=2, DATA_WIDTH=4) with hand-computed expectations.
module tb_ram_fifo_ctrl;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b0;
  logic       mode = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [1:0] addr = '0;
  logic [3:0] wdata = '0;
  logic [3:0] rdata;
  logic       rvalid;
  logic [2:0] count;
  logic       empty, full, ovf, udf;

  int total = 0;
  int bad = 0;

  // Snapshot of outputs right after the operation edge.
  logic [3:0] s_rdata;
  logic [2:0] s_count;
  logic       s_rvalid, s_empty, s_full, s_ovf, s_udf;

  ram_fifo_ctrl #(.ADDR_WIDTH(2), .DATA_WIDTH(4)) dut (
    .clk_2(clk_2), .reset(reset), .mode(mode), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .count(count),
    .empty(empty), .full(full), .ovf(ovf), .udf(udf)
  );

  always #5 clk_2 = ~clk_2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One operation cycle (snapshotted), then one idle cycle so strobes also work edge-style.
  task automatic op(input logic m, input logic w, input logic r, input logic [1:0] a,
                    input logic [3:0] d, input logic rst);
    mode = m; wr_en = w; rd_en = r; addr = a; wdata = d; reset = rst;
    @(posedge clk_2); #1;
    s_rdata = rdata; s_rvalid = rvalid; s_count = count;
    s_empty = empty; s_full = full; s_ovf = ovf; s_udf = udf;
    wr_en = 1'b0; rd_en = 1'b0; reset = 1'b0;
    @(posedge clk_2); #1;
  endtask

  task automatic push(input logic [3:0] d); op(1'b1, 1'b1, 1'b0, 2'd0, d, 1'b0); endtask
  task automatic pop();                     op(1'b1, 1'b0, 1'b1, 2'd0, 4'd0, 1'b0); endtask

  initial begin
    // Reset
    op(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1);
    chk("rst_rdata", s_rdata, 0);  chk("rst_rvalid", s_rvalid, 0);
    chk("rst_count", s_count, 0);  chk("rst_empty", s_empty, 1);
    chk("rst_full", s_full, 0);    chk("rst_ovf", s_ovf, 0);
    chk("rst_udf", s_udf, 0);

    // RAM mode
    op(1'b0, 1'b1, 1'b0, 2'd2, 4'hA, 1'b0);
    chk("ram_wr_rvalid", s_rvalid, 0);
    op(1'b0, 1'b0, 1'b1, 2'd2, 4'h0, 1'b0);
    chk("ram_rd_rdata", s_rdata, 4'hA); chk("ram_rd_rvalid", s_rvalid, 1);
    chk("ram_rvalid_pulse", rvalid, 0); chk("ram_rdata_hold", rdata, 4'hA);
    op(1'b0, 1'b1, 1'b0, 2'd1, 4'h5, 1'b0);
    op(1'b0, 1'b0, 1'b1, 2'd1, 4'h0, 1'b0);
    chk("ram_rd1", s_rdata, 4'h5);
    op(1'b0, 1'b1, 1'b1, 2'd1, 4'h6, 1'b0);
    chk("ram_both_rvalid", s_rvalid, 0); chk("ram_both_rdata", s_rdata, 4'h5);
    op(1'b0, 1'b0, 1'b1, 2'd1, 4'h0, 1'b0);
    chk("ram_both_wrote", s_rdata, 4'h6); chk("ram_count", s_count, 0);

    // Switch to FIFO: the push in the mode-change cycle is ignored
    op(1'b1, 1'b1, 1'b0, 2'd0, 4'hF, 1'b0);
    chk("mchg_count", s_count, 0);
    push(4'h1); chk("push1_count", s_count, 1); chk("push1_empty", s_empty, 0);
    push(4'h2); push(4'h3);
    push(4'h4); chk("fill_count", s_count, 4); chk("fill_full", s_full, 1);
    chk("fill_ovf", s_ovf, 0);
    push(4'h5); chk("ovf_flag", s_ovf, 1); chk("ovf_count", s_count, 4);
    pop(); chk("pop1", s_rdata, 4'h1); chk("pop1_rvalid", s_rvalid, 1);
    chk("pop1_count", s_count, 3);
    pop(); chk("pop2", s_rdata, 4'h2);
    pop(); chk("pop3", s_rdata, 4'h3);
    pop(); chk("pop4", s_rdata, 4'h4); chk("pop4_empty", s_empty, 1);

    // Underflow and simultaneous ops on empty
    pop(); chk("udf_flag", s_udf, 1); chk("udf_rdata", s_rdata, 4'h4);
    chk("udf_rvalid", s_rvalid, 0);
    op(1'b1, 1'b1, 1'b1, 2'd0, 4'h7, 1'b0);
    chk("pp_empty_count", s_count, 1); chk("pp_empty_rvalid", s_rvalid, 0);
    op(1'b1, 1'b1, 1'b1, 2'd0, 4'h8, 1'b0);
    chk("pp_rdata", s_rdata, 4'h7); chk("pp_count", s_count, 1);
    pop(); chk("pop8", s_rdata, 4'h8); chk("pop8_count", s_count, 0);

    // Wrap-around
    push(4'hD); push(4'hE); push(4'hF);
    pop(); pop(); pop(); chk("wrap_pre", s_rdata, 4'hF);
    push(4'h9); push(4'hA); push(4'hB); push(4'hC);
    chk("wrap_count", s_count, 4); chk("wrap_full", s_full, 1);
    pop(); chk("wrap_pop9", s_rdata, 4'h9);
    pop(); chk("wrap_popA", s_rdata, 4'hA);
    pop(); chk("wrap_popB", s_rdata, 4'hB);
    pop(); chk("wrap_popC", s_rdata, 4'hC); chk("wrap_empty", s_empty, 1);

    // Push while full with simultaneous pop: push rejected, pop proceeds
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    op(1'b1, 1'b1, 1'b1, 2'd0, 4'h5, 1'b0);
    chk("fullpp_ovf", s_ovf, 1); chk("fullpp_count", s_count, 3);
    chk("fullpp_rdata", s_rdata, 4'h1); chk("fullpp_rvalid", s_rvalid, 1);
    pop(); chk("fullpp_pop", s_rdata, 4'h2); chk("pre_mchg_count", s_count, 2);
    chk("pre_mchg_udf", s_udf, 1);

    // Mode change clears status; memory survives
    op(1'b0, 1'b1, 1'b1, 2'd3, 4'h0, 1'b0);
    chk("mchg_count2", s_count, 0); chk("mchg_ovf", s_ovf, 0);
    chk("mchg_udf", s_udf, 0); chk("mchg_rvalid", s_rvalid, 0);
    chk("mchg_rdata", s_rdata, 4'h2);
    op(1'b0, 1'b0, 1'b1, 2'd0, 4'h0, 1'b0); chk("mem_keep0", s_rdata, 4'h4);
    op(1'b0, 1'b0, 1'b1, 2'd3, 4'h0, 1'b0); chk("mem_keep3", s_rdata, 4'h3);

    // Reset during a push
    op(1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
    push(4'h3); chk("prerst_count", s_count, 1);
    op(1'b1, 1'b1, 1'b0, 2'd0, 4'h6, 1'b1);
    chk("rst2_count", s_count, 0); chk("rst2_rdata", s_rdata, 0);
    chk("rst2_empty", s_empty, 1); chk("rst2_rvalid", s_rvalid, 0);
    chk("rst2_after", count, 0);
    pop(); chk("rst2_udf", s_udf, 1); chk("rst2_norvalid", s_rvalid, 0);

    // Level held high for 5 cycles
    mode = 1'b1; wr_en = 1'b1; wdata = 4'h6;
    repeat (5) @(posedge clk_2);
    #1;
`ifdef RAM_FIFO_EDGE_EN
    chk("hold_count", count, 1); chk("hold_ovf", ovf, 0);
`else
    chk("hold_count", count, 4); chk("hold_ovf", ovf, 1);
`endif
    wr_en = 1'b0;
    @(posedge clk_2); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
